// File: rtl/tse_ddr_pipelined_responder.sv
// Avalon-MM pipelined responder backed by on-chip RAM; in-order read returns after READ_LATENCY cycles.
// Optional periodic waitrequest injection is enabled by defining TSE_DDR_RESP_WAIT_INJECT_EN.
module tse_ddr_pipelined_responder #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 24,
    parameter int MEM_AW         = 10,
    parameter int READ_LATENCY   = 4,
    parameter int MAX_PENDING    = 8,
    parameter int PKT_WORDS_LOG2 = 2,
    parameter int WAIT_PERIOD    = 16,
    parameter int WAIT_LEN       = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     s_address,
    input  logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_read,
    input  logic                  s_write,
    input  logic [DATA_W-1:0]     s_writedata,
    output logic                  s_waitrequest,
    output logic [DATA_W-1:0]     s_readdata,
    output logic                  s_readdatavalid,
    output logic                  s_endofpacket,
    output logic [5:0]            pending_count,
    output logic                  protocol_error
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << MEM_AW;
    localparam logic [ADDR_W-1:0] PKT_MASK = ADDR_W'((1 << PKT_WORDS_LOG2) - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [MEM_AW-1:0] mem_idx;
    logic              wr_acc;
    logic              rd_acc;
    logic              rd_eop;
    logic              inject_stall;

    logic              vld_q [READ_LATENCY];
    logic [DATA_W-1:0] dat_q [READ_LATENCY];
    logic              eop_q [READ_LATENCY];
    logic              in_vld [READ_LATENCY];
    logic [DATA_W-1:0] in_dat [READ_LATENCY];
    logic              in_eop [READ_LATENCY];

    assign mem_idx = s_address[MEM_AW-1:0];
    // A simultaneous read+write is treated as a write; the read half is dropped.
    assign wr_acc  = s_write & ~s_waitrequest;
    assign rd_acc  = s_read & ~s_write & ~s_waitrequest;
    assign rd_eop  = ((s_address & PKT_MASK) == PKT_MASK);

`ifdef TSE_DDR_RESP_WAIT_INJECT_EN
    localparam int PW = (WAIT_PERIOD > 1) ? $clog2(WAIT_PERIOD) : 1;
    logic [PW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if (wait_cnt == PW'(WAIT_PERIOD - 1))
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign inject_stall = (wait_cnt < PW'(WAIT_LEN));
`else
    assign inject_stall = 1'b0;
`endif

    assign s_waitrequest = reset | (pending_count >= 6'(MAX_PENDING)) | inject_stall;

    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (wr_acc && s_byteenable[b])
                mem[mem_idx][b*8 +: 8] <= s_writedata[b*8 +: 8];
        end
    end

    // Stage 0 captures the RAM word; later stages only load on a valid so the
    // final stage holds the last returned word between returns.
    always_comb begin
        for (int i = 0; i < READ_LATENCY; i++) begin
            in_vld[i] = 1'b0;
            in_dat[i] = '0;
            in_eop[i] = 1'b0;
        end
        in_vld[0] = rd_acc;
        in_dat[0] = mem[mem_idx];
        in_eop[0] = rd_eop;
        for (int i = 1; i < READ_LATENCY; i++) begin
            in_vld[i] = vld_q[i-1];
            in_dat[i] = dat_q[i-1];
            in_eop[i] = eop_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
                eop_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_q[i] <= in_vld[i];
                if (in_vld[i]) begin
                    dat_q[i] <= in_dat[i];
                    eop_q[i] <= in_eop[i];
                end
            end
        end
    end

    assign s_readdatavalid = vld_q[READ_LATENCY-1];
    assign s_readdata      = dat_q[READ_LATENCY-1];
    assign s_endofpacket   = eop_q[READ_LATENCY-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_count  <= '0;
            protocol_error <= 1'b0;
        end else begin
            case ({rd_acc, s_readdatavalid})
                2'b10:   pending_count <= pending_count + 6'd1;
                2'b01:   pending_count <= pending_count - 6'd1;
                default: pending_count <= pending_count;
            endcase
            if (s_read && s_write)
                protocol_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tse_ddr_pipelined_responder.sv
// Directed bench for tse_ddr_pipelined_responder: default instance plus a MAX_PENDING=2 instance
// sharing clock, reset, address and write signals.
module tb_tse_ddr_pipelined_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] s_address = '0;
    logic [3:0]  s_byteenable = '0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    logic        s_read2 = 1'b0;

    logic        wr, rdv, eop, perr;
    logic [31:0] rd;
    logic [5:0]  pend;
    logic        wr2, rdv2, eop2, perr2;
    logic [31:0] rd2;
    logic [5:0]  pend2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tse_ddr_pipelined_responder dut (
        .clk(clk), .reset(reset), .s_address(s_address), .s_byteenable(s_byteenable),
        .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_waitrequest(wr), .s_readdata(rd), .s_readdatavalid(rdv), .s_endofpacket(eop),
        .pending_count(pend), .protocol_error(perr)
    );

    tse_ddr_pipelined_responder #(.MAX_PENDING(2)) dut2 (
        .clk(clk), .reset(reset), .s_address(s_address), .s_byteenable(s_byteenable),
        .s_read(s_read2), .s_write(s_write), .s_writedata(s_writedata),
        .s_waitrequest(wr2), .s_readdata(rd2), .s_readdatavalid(rdv2), .s_endofpacket(eop2),
        .pending_count(pend2), .protocol_error(perr2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [23:0] a, input logic [31:0] d, input logic [3:0] be);
        s_address = a; s_writedata = d; s_byteenable = be; s_write = 1'b1;
        for (int i = 0; i < 40 && wr; i++) step();
        step();
        s_write = 1'b0;
    endtask

    // Returns cycles from accept to readdatavalid (1 = cycle after accept).
    task automatic do_read(input logic [23:0] a, output logic [31:0] d, output logic e, output int lat);
        s_address = a; s_read = 1'b1;
        for (int i = 0; i < 40 && wr; i++) step();
        step();
        s_read = 1'b0;
        lat = 1;
        while (!rdv && lat < 20) begin
            step();
            lat++;
        end
        d = rd; e = eop;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step(); step();
        n_chk++; if (wr !== 1'b1) begin n_fail++; $display("FAIL reset_waitreq got %b want 1", wr); end
        n_chk++; if (rdv !== 1'b0) begin n_fail++; $display("FAIL reset_rdv got %b want 0", rdv); end
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got %h want 0", rd); end
        n_chk++; if (eop !== 1'b0) begin n_fail++; $display("FAIL reset_eop got %b want 0", eop); end
        n_chk++; if (pend !== 6'd0) begin n_fail++; $display("FAIL reset_pending got %0d want 0", pend); end
        n_chk++; if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b want 0", perr); end
        reset = 1'b0;
        step();
        n_chk++; if (wr !== 1'b0) begin n_fail++; $display("FAIL idle_waitreq got %b want 0", wr); end
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic e; int lat;
        do_write(24'h10, 32'hDEADBEEF, 4'hF);
        do_read(24'h10, d, e, lat);
        n_chk++; if (lat != 4) begin n_fail++; $display("FAIL wr_rd_latency got %0d want 4", lat); end
        n_chk++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_data got %h want deadbeef", d); end
        n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL wr_rd_eop got %b want 0", e); end
        step();
        n_chk++; if (rdv !== 1'b0 || rd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL hold_readdata got rdv=%b data=%h want rdv=0 data=deadbeef", rdv, rd);
        end
        do_read(24'h410, d, e, lat);
        n_chk++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alias_data got %h want deadbeef", d); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] d; logic e; int lat;
        do_write(24'h3, 32'h11223344, 4'hF);
        do_write(24'h3, 32'hAABBCCDD, 4'b0101);
        do_write(24'h4, 32'h77777777, 4'h0);
        do_read(24'h3, d, e, lat);
        n_chk++; if (d !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_data got %h want 11bb33dd", d); end
        n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL be_eop got %b want 1", e); end
        do_write(24'h4, 32'h0000ABCD, 4'hF);
        do_write(24'h4, 32'h77777777, 4'h0);
        do_read(24'h4, d, e, lat);
        n_chk++; if (d !== 32'h0000ABCD) begin n_fail++; $display("FAIL be_none got %h want 0000abcd", d); end
    endtask

    task automatic test_back_to_back();
        int peak = 0; int rets = 0; int wr_hits = 0; int bad = 0;
        for (int i = 0; i < 16; i++) do_write(24'(i), 32'h100 + 32'(i), 4'hF);
        for (int idx = 0; idx < 23; idx++) begin
            if (idx < 16) begin s_read = 1'b1; s_address = 24'(idx); end
            else s_read = 1'b0;
            if (idx < 16 && wr) wr_hits++;
            step();
            if (int'(pend) > peak) peak = int'(pend);
            if (idx >= 3 && idx <= 18) begin
                n_chk++;
                if (rdv !== 1'b1 || rd !== 32'h100 + 32'(idx - 3) || eop !== (((idx - 3) % 4) == 3)) begin
                    n_fail++; bad++;
                    $display("FAIL b2b_return idx=%0d got rdv=%b data=%h eop=%b want 1 %h %b",
                             idx, rdv, rd, eop, 32'h100 + 32'(idx - 3), ((idx - 3) % 4) == 3);
                end
            end else if (rdv) begin
                n_fail++; $display("FAIL b2b_stray idx=%0d got rdv=1 want 0", idx);
            end
            if (rdv) rets++;
        end
        n_chk++; if (rets != 16) begin n_fail++; $display("FAIL b2b_count got %0d want 16", rets); end
        n_chk++; if (peak != 4) begin n_fail++; $display("FAIL b2b_peak got %0d want 4", peak); end
        n_chk++; if (wr_hits != 0) begin n_fail++; $display("FAIL b2b_waitreq got %0d want 0", wr_hits); end
        n_chk++; if (pend !== 6'd0) begin n_fail++; $display("FAIL b2b_drain got %0d want 0", pend); end
    endtask

    task automatic test_pending_limit();
        int next = 0; int ret = 0; int peak = 0; int stalls = 0;
        for (int i = 0; i < 6; i++) do_write(24'(i), 32'h200 + 32'(i), 4'hF);
        for (int c = 0; c < 80 && ret < 6; c++) begin
            s_read2 = (next < 6);
            s_address = 24'(next);
            n_chk++;
            if (wr2 !== (pend2 >= 6'd2)) begin
                n_fail++; $display("FAIL lim_waitreq got %b want %b (pending %0d)", wr2, pend2 >= 6'd2, pend2);
            end
            if (wr2 && s_read2) stalls++;
            if (s_read2 && !wr2) next++;
            step();
            if (int'(pend2) > peak) peak = int'(pend2);
            if (rdv2) begin
                n_chk++;
                if (rd2 !== 32'h200 + 32'(ret)) begin
                    n_fail++; $display("FAIL lim_order got %h want %h", rd2, 32'h200 + 32'(ret));
                end
                ret++;
            end
        end
        s_read2 = 1'b0;
        n_chk++; if (ret != 6) begin n_fail++; $display("FAIL lim_count got %0d want 6", ret); end
        n_chk++; if (peak != 2) begin n_fail++; $display("FAIL lim_peak got %0d want 2", peak); end
        n_chk++; if (stalls == 0) begin n_fail++; $display("FAIL lim_stalled got %0d want >0", stalls); end
    endtask

    task automatic test_reset_inflight();
        int stray = 0;
        for (int i = 0; i < 3; i++) begin
            s_read = 1'b1; s_address = 24'(i);
            step();
        end
        s_read = 1'b0;
        n_chk++; if (pend !== 6'd3) begin n_fail++; $display("FAIL rst_pre_pending got %0d want 3", pend); end
        reset = 1'b1;
        step();
        n_chk++; if (wr !== 1'b1 || rdv !== 1'b0 || pend !== 6'd0) begin
            n_fail++; $display("FAIL rst_during got wr=%b rdv=%b pend=%0d want 1 0 0", wr, rdv, pend);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rdv) stray++;
        end
        n_chk++; if (stray != 0) begin n_fail++; $display("FAIL rst_stray got %0d want 0", stray); end
        n_chk++; if (pend !== 6'd0) begin n_fail++; $display("FAIL rst_pending got %0d want 0", pend); end
    endtask

    task automatic test_protocol_error();
        logic [31:0] d; logic e; int lat; int stray = 0;
        s_address = 24'h5; s_writedata = 32'h5; s_byteenable = 4'hF;
        s_read = 1'b1; s_write = 1'b1;
        for (int i = 0; i < 40 && wr; i++) step();
        step();
        s_read = 1'b0; s_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rdv || pend != 6'd0) stray++;
            step();
        end
        n_chk++; if (stray != 0) begin n_fail++; $display("FAIL perr_noreturn got %0d want 0", stray); end
        n_chk++; if (perr !== 1'b1) begin n_fail++; $display("FAIL perr_set got %b want 1", perr); end
        do_read(24'h5, d, e, lat);
        n_chk++; if (d !== 32'h5) begin n_fail++; $display("FAIL perr_data got %h want 5", d); end
        n_chk++; if (perr !== 1'b1) begin n_fail++; $display("FAIL perr_sticky got %b want 1", perr); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        n_chk++; if (perr !== 1'b0) begin n_fail++; $display("FAIL perr_clear got %b want 0", perr); end
    endtask

`ifdef TSE_DDR_RESP_WAIT_INJECT_EN
    task automatic test_wait_inject();
        int hi = 0;
        for (int i = 0; i < 32; i++) begin
            if (wr) hi++;
            step();
        end
        n_chk++; if (hi != 6) begin n_fail++; $display("FAIL inject_count got %0d want 6", hi); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
`ifdef TSE_DDR_RESP_WAIT_INJECT_EN
        test_wait_inject();
`else
        test_back_to_back();
        test_pending_limit();
`endif
        test_reset_inflight();
        test_protocol_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
